stage_seq: RTL and testbench
============================

STAGE_SEQ -- requirements
Module: stage_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline stage strobes (legal range 2..16).
REQ-002 SHALL have parameter MEM_STAGE, default 3, index of the stage that honours memory wait states (0..NUM_STAGES-1).
REQ-003 SHALL have parameter WAIT_W, default 4, width of the wait-state request.
REQ-004 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; no other clocks; stage clocks are replaced by strobes.
REQ-006 i_clk  input  1  sole clock, rising edge.
REQ-007 i_reset  input  1  asynchronous, active-high reset.
REQ-008 i_enable  input  1  permit a new instruction to start.
REQ-009 i_stall  input  1  hold the current stage; suppress its strobe.
REQ-010 i_flush  input  1  abort the current instruction; return to stage 0.
REQ-011 i_memWait  input  WAIT_W  extra cycles to hold before the MEM_STAGE strobe.
REQ-012 o_stageEn  output  NUM_STAGES  one-hot stage strobe, one bit per stage, or all-zero.
REQ-013 o_stageIdx  output  $clog2(NUM_STAGES)  current stage index.
REQ-014 o_instrDone  output  1  high in the cycle the last-stage strobe is issued.
REQ-015 o_instrCount  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.
REQ-016 o_busy  output  1  high whenever the state is not S_IDLE.

Function
REQ-017 SHALL implement states S_IDLE, S_STAGE and S_MEMWAIT.
REQ-018 S_IDLE: o_stageEn=0; i_enable high at an edge -> S_STAGE with idx=0, so the stage-0 strobe appears in the next cycle.
REQ-019 S_STAGE: o_stageEn=onehot(idx) unless i_stall; this i_stall masking is the only combinational input-to-output path.
REQ-020 At each unstalled S_STAGE edge with idx<NUM_STAGES-1: idx increments.
REQ-021 When idx is about to become MEM_STAGE: i_memWait is latched into a down-counter; nonzero -> S_MEMWAIT, zero -> S_STAGE.
REQ-022 S_MEMWAIT: o_stageEn=0 and o_stageIdx=MEM_STAGE; the counter decrements each unstalled cycle; when it reaches 0 -> S_STAGE, and the MEM strobe follows.
REQ-023 Last stage (idx=NUM_STAGES-1), unstalled: o_instrDone=1 in that cycle; o_instrCount increments at the edge; idx becomes 0; i_enable high -> S_STAGE, low -> S_IDLE.
REQ-024 Latency: the instruction occupies NUM_STAGES+W cycles, with W the latched wait, back-to-back with no bubble while i_enable stays high.
REQ-025 i_enable falling mid-instruction SHALL NOT abort it; the instruction completes, then the block idles.
REQ-026 Priority at each edge: i_reset > i_flush > i_stall > advance.
REQ-027 i_flush: idx=0; wait counter cleared; no o_instrDone and no count increment; next state is S_STAGE if i_enable is high, else S_IDLE; i_flush in S_IDLE leaves the state unchanged.
REQ-028 i_stall: state, idx and wait counter are frozen; o_instrDone=0.
REQ-029 o_instrCount at all-ones SHALL wrap to 0 on the next retire, with no flag.

Reset
REQ-030 i_reset asserted at any time, mid-instruction included: state=S_IDLE, idx=0, wait counter=0, o_stageEn=0, o_instrDone=0, o_instrCount=0, o_busy=0.
REQ-031 After reset deasserts, the first strobe appears no earlier than one cycle after i_enable is sampled high.

Structure
REQ-032 A shared package stage_seq_pkg SHALL hold the state enum and default parameter constants: NUM_STAGES, MEM_STAGE, WAIT_W, CNT_W.
REQ-033 The wait down-counter SHALL be the sub-module stage_wait_cnt, with load, decrement-enable, clear and zero-flag.

Verification (NUM_STAGES=5, MEM_STAGE=3)
REQ-034 Basic: reset, i_enable=1, i_memWait=0 -> strobes 00001,00010,00100,01000,10000 on consecutive cycles; o_instrDone with 10000; count=1.
REQ-035 Wait: i_memWait=3 -> after 00100, three zero-strobe cycles with idx=3, then 01000; instruction lasts 8 cycles.
REQ-036 Stall: i_stall high 2 cycles during stage 1 -> 00010 masked for those cycles, then resumes; total 7 cycles; count=1.
REQ-037 Flush: i_flush during stage 2 with i_enable=1 -> next strobe 00001; count unchanged; no o_instrDone.
REQ-038 Reset during S_MEMWAIT -> all outputs zero immediately, asynchronously; o_busy=0.
REQ-039 Wrap: CNT_W=4, 16 back-to-back instructions -> count returns to 0 with no bubble between instructions.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// -----------------------------------------------------------------------------
// stage_seq_pkg
// Shared definitions for the stage sequencer: sequencer state encoding and
// the default values of the stage_seq / stage_wait_cnt parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package stage_seq_pkg;

    localparam int DEFAULT_NUM_STAGES = 5;   // stage strobes, legal 2..16
    localparam int DEFAULT_MEM_STAGE  = 3;   // stage that honours wait states
    localparam int DEFAULT_WAIT_W     = 4;   // width of the wait-state request
    localparam int DEFAULT_CNT_W      = 32;  // width of the retired counter

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STAGE   = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

endpackage : stage_seq_pkg

// File: rtl/stage_wait_cnt.sv
// -----------------------------------------------------------------------------
// stage_wait_cnt
// Memory wait-state down-counter used by stage_seq.
// Priority: clear > load > decrement. Decrement saturates at zero.
//
// Ports
//   i_clk      input   1       sole clock, rising edge
//   i_reset    input   1       asynchronous, active-high reset
//   i_clear    input   1       force the count to zero
//   i_load     input   1       load i_load_val
//   i_load_val input   WAIT_W  value to load
//   i_dec      input   1       decrement by one (ignored at zero)
//   o_count    output  WAIT_W  current count
//   o_zero     output  1       count is zero
// -----------------------------------------------------------------------------
module stage_wait_cnt
    import stage_seq_pkg::*;
#(
    parameter int WAIT_W = DEFAULT_WAIT_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic [WAIT_W-1:0] o_count,
    output logic              o_zero
);

    logic [WAIT_W-1:0] r_count;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WAIT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule : stage_wait_cnt

// File: rtl/stage_seq.sv
// -----------------------------------------------------------------------------
// stage_seq
// Single-clock pipeline stage sequencer. Replaces per-stage clocks with a
// one-hot strobe vector; one instruction walks stages 0..NUM_STAGES-1, with
// optional wait states held in front of the MEM_STAGE strobe.
//
// Ports
//   i_clk        input   1                   sole clock, rising edge
//   i_reset      input   1                   asynchronous, active-high reset
//   i_enable     input   1                   permit a new instruction to start
//   i_stall      input   1                   hold current stage, mask strobe
//   i_flush      input   1                   abort instruction, back to stage 0
//   i_memWait    input   WAIT_W              wait cycles before MEM strobe
//   o_stageEn    output  NUM_STAGES          one-hot stage strobe or zero
//   o_stageIdx   output  $clog2(NUM_STAGES)  current stage index
//   o_instrDone  output  1                   last-stage strobe issued this cycle
//   o_instrCount output  CNT_W               retired instructions, wrapping
//   o_busy       output  1                   state is not S_IDLE
// -----------------------------------------------------------------------------
module stage_seq
    import stage_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int MEM_STAGE  = DEFAULT_MEM_STAGE,
    parameter int WAIT_W     = DEFAULT_WAIT_W,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_stall,
    input  logic                          i_flush,
    input  logic [WAIT_W-1:0]             i_memWait,
    output logic [NUM_STAGES-1:0]         o_stageEn,
    output logic [$clog2(NUM_STAGES)-1:0] o_stageIdx,
    output logic                          o_instrDone,
    output logic [CNT_W-1:0]              o_instrCount,
    output logic                          o_busy
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] MEM_IDX  = IDX_W'(MEM_STAGE);
    localparam logic [NUM_STAGES-1:0] STROBE_0 = NUM_STAGES'(1);

    if (NUM_STAGES < 2 || NUM_STAGES > 16) begin : g_bad_num_stages
        $error("stage_seq: NUM_STAGES must be in 2..16");
    end
    if (MEM_STAGE < 0 || MEM_STAGE >= NUM_STAGES) begin : g_bad_mem_stage
        $error("stage_seq: MEM_STAGE must be in 0..NUM_STAGES-1");
    end

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_count;

    state_t            w_next_state;
    logic [IDX_W-1:0]  w_next_idx;
    logic              w_enter;      // advancing into a new stage this edge
    logic              w_retire;     // last stage completes this edge
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_clr;
    logic [WAIT_W-1:0] w_wait_cnt;
    logic              w_wait_zero;

    // -------------------------------------------------------------------------
    // Wait-state counter
    // -------------------------------------------------------------------------
    stage_wait_cnt #(
        .WAIT_W (WAIT_W)
    ) u_wait_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (i_memWait),
        .i_dec      (w_cnt_dec),
        .o_count    (w_wait_cnt),
        .o_zero     (w_wait_zero)
    );

    // -------------------------------------------------------------------------
    // State register (plus stage index and retired count)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);  // wraps silently at all-ones
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: flush > stall > advance.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so
        // no path through the branches leaves it unassigned (no latch).
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_enter      = 1'b0;
        w_retire     = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_cnt_clr    = 1'b0;

        if (i_flush) begin
            w_next_idx = '0;
            w_cnt_clr  = 1'b1;
            if (r_state != S_IDLE) begin
                w_next_state = i_enable ? S_STAGE : S_IDLE;
            end
        end else if (!i_stall) begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        w_next_idx = '0;
                        w_enter    = 1'b1;
                    end
                end
                S_STAGE: begin
                    if (r_idx == LAST_IDX) begin
                        w_retire   = 1'b1;
                        w_next_idx = '0;
                        if (i_enable) begin
                            w_enter = 1'b1;        // back-to-back, no bubble
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end else begin
                        w_next_idx = r_idx + IDX_W'(1);
                        w_enter    = 1'b1;
                    end
                end
                S_MEMWAIT: begin
                    // Leave on the edge where the counter reaches zero, so the
                    // number of blank cycles equals the latched wait exactly.
                    w_cnt_dec = 1'b1;
                    if (w_wait_zero || (w_wait_cnt == WAIT_W'(1))) begin
                        w_next_state = S_STAGE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_idx   = '0;
                end
            endcase

            // Entering the memory stage samples the wait request; a non-zero
            // request holds the strobe off in S_MEMWAIT.
            if (w_enter) begin
                w_next_state = S_STAGE;
                if (w_next_idx == MEM_IDX) begin
                    w_cnt_load = 1'b1;
                    if (i_memWait != '0) begin
                        w_next_state = S_MEMWAIT;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output logic. i_stall is the only input reaching outputs combinationally;
    // i_flush acts at the edge, so a flush in the last stage still shows the
    // strobe and o_instrDone for that cycle but does not count the retire.
    // -------------------------------------------------------------------------
    always_comb begin
        o_stageEn   = '0;
        o_instrDone = 1'b0;
        if ((r_state == S_STAGE) && !i_stall) begin
            o_stageEn   = STROBE_0 << r_idx;
            o_instrDone = (r_idx == LAST_IDX);
        end
    end

    assign o_stageIdx   = r_idx;
    assign o_instrCount = r_count;
    assign o_busy       = (r_state != S_IDLE);

endmodule : stage_seq

// File: tb/tb_stage_seq.sv
module tb_stage_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       stall;
    logic       flush;
    logic [3:0] mem_wait;

    logic [4:0]  stage_en,  stage_en_b;
    logic [2:0]  stage_idx, stage_idx_b;
    logic        done,      done_b;
    logic [31:0] count;
    logic [3:0]  count_b;
    logic        busy,      busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_seq #(
        .NUM_STAGES(5), .MEM_STAGE(3), .WAIT_W(4), .CNT_W(32)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall),
        .i_flush(flush), .i_memWait(mem_wait),
        .o_stageEn(stage_en), .o_stageIdx(stage_idx), .o_instrDone(done),
        .o_instrCount(count), .o_busy(busy)
    );

    // Narrow-counter copy driven by the same stimulus, for the wrap scenario.
    stage_seq #(
        .NUM_STAGES(5), .MEM_STAGE(3), .WAIT_W(4), .CNT_W(4)
    ) dut_w4 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall),
        .i_flush(flush), .i_memWait(mem_wait),
        .o_stageEn(stage_en_b), .o_stageIdx(stage_idx_b), .o_instrDone(done_b),
        .o_instrCount(count_b), .o_busy(busy_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; stall = 1'b0; flush = 1'b0; mem_wait = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; stall = 1'b0; flush = 1'b0; mem_wait = '0;
        #2;
        checks++; if (stage_en !== 5'b0) begin errors++; $display("FAIL reset_en: got %b want 00000", stage_en); end
        checks++; if (stage_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", stage_idx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick();
        rst = 1'b0;
        tick();   // enable low at this edge: stays idle
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        en = 1'b1;
        #1;
        checks++; if (stage_en !== 5'b0) begin errors++; $display("FAIL idle_no_comb_en: got %b want 00000", stage_en); end
        tick();
        checks++; if (stage_en !== 5'b00001) begin errors++; $display("FAIL first_strobe: got %b want 00001", stage_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b want 1", busy); end
    endtask

    task automatic test_basic;
        logic [4:0] one = 5'b00001;
        logic [4:0] exp_en;
        do_reset();
        en = 1'b1; mem_wait = 4'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) en = 1'b0;   // dropping enable must not abort
            exp_en = one << k;
            checks++; if (stage_en !== exp_en) begin errors++; $display("FAIL basic_en c%0d: got %b want %b", k, stage_en, exp_en); end
            checks++; if (stage_idx !== 3'(k)) begin errors++; $display("FAIL basic_idx c%0d: got %0d want %0d", k, stage_idx, k); end
            checks++; if (done !== (k == 4)) begin errors++; $display("FAIL basic_done c%0d: got %b want %b", k, done, (k == 4)); end
        end
        tick();
        checks++; if (count !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", busy); end
        checks++; if (stage_en !== 5'b0) begin errors++; $display("FAIL basic_idle_en: got %b want 00000", stage_en); end
    endtask

    task automatic test_wait;
        logic [4:0] exp_en  [8] = '{5'b00001, 5'b00010, 5'b00100, 5'b00000,
                                    5'b00000, 5'b00000, 5'b01000, 5'b10000};
        logic [2:0] exp_idx [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        do_reset();
        en = 1'b1; mem_wait = 4'd3;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) en = 1'b0;
            checks++; if (stage_en !== exp_en[c]) begin errors++; $display("FAIL wait_en c%0d: got %b want %b", c, stage_en, exp_en[c]); end
            checks++; if (stage_idx !== exp_idx[c]) begin errors++; $display("FAIL wait_idx c%0d: got %0d want %0d", c, stage_idx, exp_idx[c]); end
            checks++; if (done !== (c == 7)) begin errors++; $display("FAIL wait_done c%0d: got %b want %b", c, done, (c == 7)); end
        end
        tick();
        checks++; if (count !== 32'd1) begin errors++; $display("FAIL wait_count: got %0d want 1", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: got %b want 0", busy); end
    endtask

    task automatic test_stall;
        logic       stl     [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [4:0] exp_en  [7] = '{5'b00001, 5'b00000, 5'b00000, 5'b00010,
                                    5'b00100, 5'b01000, 5'b10000};
        logic [2:0] exp_idx [7] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        do_reset();
        en = 1'b1; mem_wait = 4'd0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 0) en = 1'b0;
            stall = stl[c];
            #1;
            checks++; if (stage_en !== exp_en[c]) begin errors++; $display("FAIL stall_en c%0d: got %b want %b", c, stage_en, exp_en[c]); end
            checks++; if (stage_idx !== exp_idx[c]) begin errors++; $display("FAIL stall_idx c%0d: got %0d want %0d", c, stage_idx, exp_idx[c]); end
            checks++; if (done !== (c == 6)) begin errors++; $display("FAIL stall_done c%0d: got %b want %b", c, done, (c == 6)); end
        end
        stall = 1'b0;
        tick();
        checks++; if (count !== 32'd1) begin errors++; $display("FAIL stall_count: got %0d want 1", count); end
    endtask

    task automatic test_flush;
        logic [4:0] exp_en [4] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
        do_reset();
        en = 1'b1; mem_wait = 4'd0;
        tick();   // stage 0
        tick();   // stage 1
        tick();   // stage 2
        flush = 1'b1;
        #1;
        checks++; if (stage_en !== 5'b00100) begin errors++; $display("FAIL flush_no_comb: got %b want 00100", stage_en); end
        tick();
        flush = 1'b0; en = 1'b0;
        checks++; if (stage_en !== 5'b00001) begin errors++; $display("FAIL flush_restart: got %b want 00001", stage_en); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", done); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (stage_en !== exp_en[c]) begin errors++; $display("FAIL flush_en c%0d: got %b want %b", c, stage_en, exp_en[c]); end
        end
        tick();
        checks++; if (count !== 32'd1) begin errors++; $display("FAIL flush_final_count: got %0d want 1", count); end
    endtask

    // Continues from test_flush (idle, count=1) so the reset visibly clears it.
    task automatic test_reset_memwait;
        en = 1'b1; mem_wait = 4'd3;
        tick();
        en = 1'b0;
        tick();
        tick();
        tick();   // now holding in S_MEMWAIT
        checks++; if (stage_idx !== 3'd3) begin errors++; $display("FAIL memwait_idx: got %0d want 3", stage_idx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL memwait_busy: got %b want 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (stage_en !== 5'b0) begin errors++; $display("FAIL areset_en: got %b want 00000", stage_en); end
        checks++; if (stage_idx !== 3'd0) begin errors++; $display("FAIL areset_idx: got %0d want 0", stage_idx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b want 0", done); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back_wrap;
        logic [4:0] one = 5'b00001;
        logic [4:0] exp_en;
        do_reset();
        en = 1'b1; mem_wait = 4'd0;
        for (int c = 0; c < 80; c++) begin
            tick();
            exp_en = one << (c % 5);
            checks++; if (stage_en !== exp_en) begin errors++; $display("FAIL b2b_en c%0d: got %b want %b", c, stage_en, exp_en); end
            checks++; if (stage_en_b !== exp_en) begin errors++; $display("FAIL b2b_en_w4 c%0d: got %b want %b", c, stage_en_b, exp_en); end
            checks++; if (done_b !== ((c % 5) == 4)) begin errors++; $display("FAIL b2b_done_w4 c%0d: got %b want %b", c, done_b, ((c % 5) == 4)); end
            if (c == 75) begin
                checks++; if (count_b !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d want 15", count_b); end
            end
        end
        en = 1'b0;
        tick();
        checks++; if (count_b !== 4'd0) begin errors++; $display("FAIL wrap_count_w4: got %0d want 0", count_b); end
        checks++; if (count !== 32'd16) begin errors++; $display("FAIL wrap_count_w32: got %0d want 16", count); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %b want 0", busy_b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_stall();
        test_flush();
        test_reset_memwait();
        test_back_to_back_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_stage_seq
